gcd_seq: RTL and testbench

Parametrised sequential GCD engine for unsigned operands of configurable width, computed by repeated subtraction (one subtraction per clock).
- The controller and datapath are integrated in one block, with a valid/ready handshake on both the operand and the result sides.
- Adds zero-operand handling, result back-pressure and synchronous abort.
- Intended as the reusable GCD unit for wider designs, replacing fixed 4-bit controller/datapath pairs.

---
 rtl/gcd_seq_if.sv | 23 ++
 rtl/gcd_seq.sv | 106 ++++++++++
 tb/tb_gcd_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_seq_if.sv
// Operand/result handshake bundle for the gcd_seq engine.
// master = producer/consumer side, slave = the GCD engine.
interface gcd_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q
    );
endinterface

// File: rtl/gcd_seq.sv
// Sequential GCD by repeated subtraction, one subtraction per clock.
// Optional step counter port enabled by defining GCD_STEP_COUNT_EN.
module gcd_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    gcd_seq_if.slave         io,
`ifdef GCD_STEP_COUNT_EN
    output logic [CNT_W-1:0] steps,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] q_r;
    logic             accept;

    // Reject parameter combinations the datapath is not built for
    if (WIDTH < 2 || WIDTH > 32 || CNT_W < 1) begin : g_bad_param
        $error("gcd_seq: unsupported WIDTH/CNT_W");
    end

    assign io.in_ready  = (state == IDLE) & ~clr;
    assign io.out_valid = (state == DONE);
    assign io.q         = q_r;
    assign busy         = (state != IDLE);
    assign accept       = io.in_valid & io.in_ready;

    // Controller and datapath: accept, subtract until equal, hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            q_r   <= '0;
        end else if (clr) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            q_r   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (io.a == '0) begin
                            q_r   <= io.b;
                            state <= DONE;
                        end else if (io.b == '0) begin
                            q_r   <= io.a;
                            state <= DONE;
                        end else begin
                            ra    <= io.a;
                            rb    <= io.b;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (ra > rb) begin
                        ra <= ra - rb;
                    end else if (rb > ra) begin
                        rb <= rb - ra;
                    end else begin
                        q_r   <= ra;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GCD_STEP_COUNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count of subtractions since the last accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || accept) begin
            cnt <= '0;
        end else if (state == CALC && ra != rb && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign steps = cnt;
`endif

endmodule

// File: tb/tb_gcd_seq.sv
// Directed self-checking bench for gcd_seq (WIDTH=8).
// Step-count checks compile only with GCD_STEP_COUNT_EN.
module tb_gcd_seq;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic busy;
    int   n_chk = 0;
    int   n_err = 0;
    int   lat;

    gcd_seq_if #(.WIDTH(8)) ifc ();

`ifdef GCD_STEP_COUNT_EN
    logic [7:0] steps;
    logic [3:0] steps4;
    logic       busy4;
    gcd_seq_if #(.WIDTH(8)) ifc4 ();

    gcd_seq #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .io    (ifc4),
        .steps (steps4),
        .busy  (busy4)
    );
`endif

    gcd_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .io    (ifc),
`ifdef GCD_STEP_COUNT_EN
        .steps (steps),
`endif
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge, then count edges until out_valid
    task automatic op(input logic [7:0] av, input logic [7:0] bv,
                      output int l);
        ifc.a        = av;
        ifc.b        = bv;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        l = 0;
        while (!ifc.out_valid && l < 600) begin
            tick();
            l++;
        end
        chk("no_timeout", {31'd0, ifc.out_valid}, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        clr           = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.out_ready = 1'b1;
`ifdef GCD_STEP_COUNT_EN
        ifc4.in_valid  = 1'b0;
        ifc4.a         = '0;
        ifc4.b         = '0;
        ifc4.out_ready = 1'b1;
`endif
        #22;
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_q", {24'd0, ifc.q}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);

        // 12,8 -> (4,8) -> (4,4): two subtractions
        op(8'd12, 8'd8, lat);
        chk("lat_12_8", lat, 32'd3);
        chk("q_12_8", {24'd0, ifc.q}, 32'd4);
        chk("busy_done", {31'd0, busy}, 32'd1);
`ifdef GCD_STEP_COUNT_EN
        chk("steps_12_8", {24'd0, steps}, 32'd2);
`endif
        tick();
        chk("idle_after", {31'd0, ifc.in_ready}, 32'd1);

        op(8'd6, 8'd6, lat);
        chk("lat_6_6", lat, 32'd1);
        chk("q_6_6", {24'd0, ifc.q}, 32'd6);
`ifdef GCD_STEP_COUNT_EN
        chk("steps_6_6", {24'd0, steps}, 32'd0);
`endif
        tick();

        op(8'd0, 8'd9, lat);
        chk("lat_0_9", lat, 32'd0);
        chk("q_0_9", {24'd0, ifc.q}, 32'd9);
        tick();

        op(8'd0, 8'd0, lat);
        chk("lat_0_0", lat, 32'd0);
        chk("q_0_0", {24'd0, ifc.q}, 32'd0);
        tick();

        op(8'd7, 8'd0, lat);
        chk("lat_7_0", lat, 32'd0);
        chk("q_7_0", {24'd0, ifc.q}, 32'd7);
        tick();

        // Worst case: 254 subtractions
        op(8'd1, 8'd255, lat);
        chk("lat_1_255", lat, 32'd255);
        chk("q_1_255", {24'd0, ifc.q}, 32'd1);
`ifdef GCD_STEP_COUNT_EN
        chk("steps_1_255", {24'd0, steps}, 32'd254);
`endif
        tick();

        // Back-pressure: 48,18 -> 30,18 -> 12,18 -> 12,6 -> 6,6
        ifc.out_ready = 1'b0;
        op(8'd48, 8'd18, lat);
        chk("lat_48_18", lat, 32'd5);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", {31'd0, ifc.out_valid}, 32'd1);
            chk("bp_q", {24'd0, ifc.q}, 32'd6);
            chk("bp_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        end
        ifc.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, ifc.in_ready}, 32'd1);
        chk("q_held_idle", {24'd0, ifc.q}, 32'd6);

        // Abort two cycles after accepting 200,3
        ifc.a        = 8'd200;
        ifc.b        = 8'd3;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        chk("clr_pre_valid", {31'd0, ifc.out_valid}, 32'd0);
        tick();
        chk("clr_busy_calc", {31'd0, busy}, 32'd1);
        chk("clr_in_ready_low", {31'd0, ifc.in_ready}, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("clr_q", {24'd0, ifc.q}, 32'd0);
`ifdef GCD_STEP_COUNT_EN
        chk("clr_steps", {24'd0, steps}, 32'd0);
`endif

        // 21,14 -> 7,14 -> 7,7
        op(8'd21, 8'd14, lat);
        chk("lat_21_14", lat, 32'd3);
        chk("q_21_14", {24'd0, ifc.q}, 32'd7);
        tick();

        // Reset during CALC of 100,75
        ifc.a        = 8'd100;
        ifc.b        = 8'd75;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_q", {24'd0, ifc.q}, 32'd0);
        chk("rst_mid_valid", {31'd0, ifc.out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_in_ready", {31'd0, ifc.in_ready}, 32'd1);

        // clr coincident with in_valid in IDLE blocks the accept
        clr          = 1'b1;
        ifc.a        = 8'd5;
        ifc.b        = 8'd10;
        ifc.in_valid = 1'b1;
        #1;
        chk("clr_idle_ready", {31'd0, ifc.in_ready}, 32'd0);
        tick();
        clr          = 1'b0;
        ifc.in_valid = 1'b0;
        chk("clr_idle_busy", {31'd0, busy}, 32'd0);
        chk("clr_idle_valid", {31'd0, ifc.out_valid}, 32'd0);

        op(8'd5, 8'd10, lat);
        chk("lat_5_10", lat, 32'd2);
        chk("q_5_10", {24'd0, ifc.q}, 32'd5);
        tick();

`ifdef GCD_STEP_COUNT_EN
        // 4-bit counter saturates at 15
        ifc4.a        = 8'd1;
        ifc4.b        = 8'd255;
        ifc4.in_valid = 1'b1;
        tick();
        ifc4.in_valid = 1'b0;
        lat = 0;
        while (!ifc4.out_valid && lat < 600) begin
            tick();
            lat++;
        end
        chk("sat_valid", {31'd0, ifc4.out_valid}, 32'd1);
        chk("sat_q", {24'd0, ifc4.q}, 32'd1);
        chk("sat_steps", {28'd0, steps4}, 32'd15);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
